// File: rtl/ov7670_stream_receiver_if.sv
// Camera pin bundle plus VGA frame-buffer write port for the OV7670 receiver.
// The receiver connects to the master modport; the camera and BRAM side connects to the slave modport.
interface ov7670_stream_receiver_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PXL_WIDTH  = 16,
   parameter int HA_W       = 10,
   parameter int VA_W       = 9
);
   logic                  i_PCLK;
   logic                  i_VS;
   logic                  i_HS;
   logic [DATA_WIDTH-1:0] i_DATA;
   logic                  o_XCLK;
   logic [PXL_WIDTH-1:0]  o_pixel_data;
   logic [HA_W-1:0]       o_h_addr;
   logic [VA_W-1:0]       o_v_addr;
   logic                  o_valid;

   modport master (
      input  i_PCLK, i_VS, i_HS, i_DATA,
      output o_XCLK, o_pixel_data, o_h_addr, o_v_addr, o_valid
   );

   modport slave (
      output i_PCLK, i_VS, i_HS, i_DATA,
      input  o_XCLK, o_pixel_data, o_h_addr, o_v_addr, o_valid
   );
endinterface

// File: rtl/ov7670_stream_receiver.sv
// OV7670 receiver: oversampled camera bus -> RGB565/RGB444/YUV-grey pixels for the VGA frame BRAM, plus XCLK.
// Optional macro OV7670_TEST_PATTERN_EN adds i_test_pattern, which replaces pixels with 8 vertical colour bars.
module ov7670_stream_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int H_WIDTH     = 320,
   parameter int V_WIDTH     = 240,
   parameter int R_WIDTH     = 5,
   parameter int G_WIDTH     = 6,
   parameter int B_WIDTH     = 5,
   parameter int PXL_WIDTH   = R_WIDTH + G_WIDTH + B_WIDTH,
   parameter int CLK_FREQ    = 100_000_000,
   parameter int XCLK_FREQ   = 25_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start_capture,
   input  logic       i_continuous,
   input  logic [1:0] i_mode,
   input  logic       i_decimate,
`ifdef OV7670_TEST_PATTERN_EN
   input  logic       i_test_pattern,
`endif
   ov7670_stream_receiver_if.master bus,
   output logic       o_busy,
   output logic       o_frame_done,
   output logic       o_size_err
);
   localparam int HA_W = $clog2(H_WIDTH) + 1;
   localparam int VA_W = $clog2(V_WIDTH) + 1;
   // One spare bit so decimated source coordinates (up to 2x the stored size) still fit.
   localparam int HC_W = HA_W + 1;
   localparam int VC_W = VA_W + 1;
   localparam logic [HC_W-1:0] H_LIM = HC_W'(H_WIDTH);
   localparam logic [VC_W-1:0] V_LIM = VC_W'(V_WIDTH);
   localparam int XDIV = CLK_FREQ / (2 * XCLK_FREQ);
   localparam int XW   = (XDIV > 1) ? $clog2(XDIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_FRAME, S_DONE} state_t;

   logic [SYNC_STAGES-1:0] r_pclk_sync, r_vs_sync, r_hs_sync;
   logic [DATA_WIDTH-1:0]  r_data_sync [SYNC_STAGES];
   logic                   r_pclk_d, r_vs_d, r_hs_d;
   logic [XW-1:0]          r_xclk_cnt;
   logic                   r_xclk;

   state_t                 r_state;
   logic                   r_vs_seen, r_phase, r_dec;
   logic [1:0]             r_mode;
   logic [7:0]             r_byte0;
   logic [HC_W-1:0]        r_h;
   logic [VC_W-1:0]        r_v;
   logic                   r_valid, r_busy, r_frame_done, r_size_err;
   logic [PXL_WIDTH-1:0]   r_pixel;
   logic [HA_W-1:0]        r_h_addr;
   logic [VA_W-1:0]        r_v_addr;

   logic                   w_pclk, w_vs, w_hs;
   logic [7:0]             w_data;
   logic                   w_pclk_rise, w_vs_rise, w_vs_fall, w_hs_fall;
   logic [HC_W-1:0]        w_h_eff;
   logic [VC_W-1:0]        w_v_eff;
   logic                   w_keep, w_in_range;
   logic [15:0]            w_565;
   logic [7:0]             w_r8, w_g8, w_b8;
   logic [PXL_WIDTH-1:0]   w_pixel;

   assign w_pclk      = r_pclk_sync[SYNC_STAGES-1];
   assign w_vs        = r_vs_sync[SYNC_STAGES-1];
   assign w_hs        = r_hs_sync[SYNC_STAGES-1];
   assign w_data      = r_data_sync[SYNC_STAGES-1][7:0];
   assign w_pclk_rise = w_pclk & ~r_pclk_d;
   assign w_vs_rise   = w_vs & ~r_vs_d;
   assign w_vs_fall   = ~w_vs & r_vs_d;
   assign w_hs_fall   = ~w_hs & r_hs_d;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pclk_sync <= '0;
         r_vs_sync   <= '0;
         r_hs_sync   <= '0;
         for (int k = 0; k < SYNC_STAGES; k++) r_data_sync[k] <= '0;
         r_pclk_d    <= 1'b0;
         r_vs_d      <= 1'b0;
         r_hs_d      <= 1'b0;
      end else begin
         for (int k = SYNC_STAGES - 1; k > 0; k--) begin
            r_pclk_sync[k] <= r_pclk_sync[k-1];
            r_vs_sync[k]   <= r_vs_sync[k-1];
            r_hs_sync[k]   <= r_hs_sync[k-1];
            r_data_sync[k] <= r_data_sync[k-1];
         end
         r_pclk_sync[0] <= bus.i_PCLK;
         r_vs_sync[0]   <= bus.i_VS;
         r_hs_sync[0]   <= bus.i_HS;
         r_data_sync[0] <= bus.i_DATA;
         r_pclk_d       <= w_pclk;
         r_vs_d         <= w_vs;
         r_hs_d         <= w_hs;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_xclk_cnt <= '0;
         r_xclk     <= 1'b0;
      end else if (r_xclk_cnt == XW'(XDIV - 1)) begin
         r_xclk_cnt <= '0;
         r_xclk     <= ~r_xclk;
      end else begin
         r_xclk_cnt <= r_xclk_cnt + 1'b1;
      end
   end

   assign w_h_eff    = r_dec ? (r_h >> 1) : r_h;
   assign w_v_eff    = r_dec ? (r_v >> 1) : r_v;
   assign w_keep     = ~r_dec | (~r_h[0] & ~r_v[0]);
   assign w_in_range = (w_h_eff < H_LIM) && (w_v_eff < V_LIM);
   assign w_565      = {r_byte0, w_data};

   // Every mode first widens its colour fields to 8 bits; the output keeps the top bits of each.
   always_comb begin
      w_r8 = {w_565[15:11], 3'b000};
      w_g8 = {w_565[10:5], 2'b00};
      w_b8 = {w_565[4:0], 3'b000};
      case (r_mode)
         2'b01: begin
            w_r8 = {r_byte0[3:0], r_byte0[3:0]};
            w_g8 = {w_data[7:4], w_data[7:4]};
            w_b8 = {w_data[3:0], w_data[3:0]};
         end
         2'b10: begin
            w_r8 = r_byte0;
            w_g8 = r_byte0;
            w_b8 = r_byte0;
         end
         default: ;
      endcase
   end

`ifdef OV7670_TEST_PATTERN_EN
   logic [2:0] w_bar;
   assign w_bar   = 3'((32'(w_h_eff) * 8) / H_WIDTH);
   // Bars run white, yellow, cyan, green, magenta, red, blue, black.
   assign w_pixel = i_test_pattern
                  ? {{R_WIDTH{~w_bar[1]}}, {G_WIDTH{~w_bar[2]}}, {B_WIDTH{~w_bar[0]}}}
                  : {w_r8[7 -: R_WIDTH], w_g8[7 -: G_WIDTH], w_b8[7 -: B_WIDTH]};
`else
   assign w_pixel = {w_r8[7 -: R_WIDTH], w_g8[7 -: G_WIDTH], w_b8[7 -: B_WIDTH]};
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_vs_seen    <= 1'b0;
         r_phase      <= 1'b0;
         r_dec        <= 1'b0;
         r_mode       <= 2'b00;
         r_byte0      <= '0;
         r_h          <= '0;
         r_v          <= '0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_size_err   <= 1'b0;
         r_pixel      <= '0;
         r_h_addr     <= '0;
         r_v_addr     <= '0;
      end else begin
         r_valid      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start_capture) begin
                  r_state    <= S_WAIT_VS;
                  r_busy     <= 1'b1;
                  r_size_err <= 1'b0;
                  r_vs_seen  <= w_vs;
               end
            end
            S_WAIT_VS: begin
               if (w_vs) r_vs_seen <= 1'b1;
               if (w_vs_fall && r_vs_seen) begin
                  r_state <= S_FRAME;
                  r_mode  <= i_mode;
                  r_dec   <= i_decimate;
                  r_h     <= '0;
                  r_v     <= '0;
                  r_phase <= 1'b0;
               end
            end
            S_FRAME: begin
               if (w_vs_rise) begin
                  r_state      <= S_DONE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end else begin
                  if (!w_hs) r_phase <= 1'b0;
                  if (w_hs_fall) begin
                     r_h <= '0;
                     if (r_h != '0 && r_v != '1) r_v <= r_v + 1'b1;
                  end
                  if (w_pclk_rise && w_hs) begin
                     if (!r_phase) begin
                        r_byte0 <= w_data;
                        r_phase <= 1'b1;
                     end else begin
                        r_phase <= 1'b0;
                        if (r_h != '1) r_h <= r_h + 1'b1;
                        if (w_keep) begin
                           if (w_in_range) begin
                              r_valid  <= 1'b1;
                              r_pixel  <= w_pixel;
                              r_h_addr <= w_h_eff[HA_W-1:0];
                              r_v_addr <= w_v_eff[VA_W-1:0];
                           end else begin
                              r_size_err <= 1'b1;
                           end
                        end
                     end
                  end
               end
            end
            S_DONE: begin
               // Automatic re-arm keeps o_size_err so software can still read it after the frame.
               if (i_continuous) begin
                  r_state   <= S_WAIT_VS;
                  r_busy    <= 1'b1;
                  r_vs_seen <= w_vs;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_XCLK       = r_xclk;
   assign bus.o_pixel_data = r_pixel;
   assign bus.o_h_addr     = r_h_addr;
   assign bus.o_v_addr     = r_v_addr;
   assign bus.o_valid      = r_valid;
   assign o_busy           = r_busy;
   assign o_frame_done     = r_frame_done;
   assign o_size_err       = r_size_err;
endmodule

// File: tb/tb_ov7670_stream_receiver.sv
// Directed bench for ov7670_stream_receiver with a 4x2 stored frame and the default 100/25 MHz clocks.
module tb_ov7670_stream_receiver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       dec = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       busy, fdone, serr;
`ifdef OV7670_TEST_PATTERN_EN
   logic       tp = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic [15:0] cap_pix [$];
   logic [2:0]  cap_h [$];
   logic [1:0]  cap_v [$];

   ov7670_stream_receiver_if #(.DATA_WIDTH(8), .PXL_WIDTH(16), .HA_W(3), .VA_W(2)) bus ();

   ov7670_stream_receiver #(.H_WIDTH(4), .V_WIDTH(2)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_start_capture (start),
      .i_continuous    (cont),
      .i_mode          (mode),
      .i_decimate      (dec),
`ifdef OV7670_TEST_PATTERN_EN
      .i_test_pattern  (tp),
`endif
      .bus             (bus),
      .o_busy          (busy),
      .o_frame_done    (fdone),
      .o_size_err      (serr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_valid) begin
         cap_pix.push_back(bus.o_pixel_data);
         cap_h.push_back(bus.o_h_addr);
         cap_v.push_back(bus.o_v_addr);
         $display("[TB] write h=%0d v=%0d pix=%h", bus.o_h_addr, bus.o_v_addr, bus.o_pixel_data);
      end
      if (fdone) begin
         done_cnt++;
         $display("[TB] frame_done #%0d", done_cnt);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_DATA = b;
      bus.i_PCLK = 1'b0;
      wait_cyc(4);
      bus.i_PCLK = 1'b1;
      wait_cyc(4);
   endtask

   task automatic send_line(input int px, input logic [7:0] b0, input logic [7:0] b1,
                            input bit pat, input int y);
      logic [7:0] first;
      bus.i_HS = 1'b1;
      wait_cyc(2);
      for (int x = 0; x < px; x++) begin
         first = pat ? {x[3:0], y[3:0]} : b0;
         send_byte(first);
         send_byte(b1);
      end
      bus.i_PCLK = 1'b0;
      wait_cyc(2);
      bus.i_HS = 1'b0;
      wait_cyc(8);
   endtask

   task automatic send_frame(input int lines, input int px, input logic [7:0] b0,
                             input logic [7:0] b1, input bit pat);
      bus.i_VS = 1'b1;
      wait_cyc(12);
      bus.i_VS = 1'b0;
      wait_cyc(12);
      for (int y = 0; y < lines; y++) send_line(px, b0, b1, pat, y);
      bus.i_VS = 1'b1;
      wait_cyc(12);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      n_tests++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
      n_tests++;
      if (bus.o_pixel_data !== 16'h0) begin n_fail++; $display("FAIL reset_pixel got %h want 0000", bus.o_pixel_data); end
      n_tests++;
      if (busy !== 1'b0 || fdone !== 1'b0 || serr !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got busy=%b done=%b err=%b want 000", busy, fdone, serr);
      end
      n_tests++;
      if (bus.o_XCLK !== 1'b0) begin n_fail++; $display("FAIL reset_xclk got %b want 0", bus.o_XCLK); end
   endtask

   task automatic test_xclk();
      logic [7:0] xexp;
      xexp = 8'b0110_0110;
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_cyc(1);
         n_tests++;
         if (bus.o_XCLK !== xexp[7-i]) begin
            n_fail++; $display("FAIL xclk_cycle%0d got %b want %b", i, bus.o_XCLK, xexp[7-i]);
         end
      end
   endtask

   task automatic test_rgb565();
      int base, based;
      base = cap_pix.size();
      based = done_cnt;
      mode = 2'b00;
      pulse_start();
      wait_cyc(2);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rgb565_busy_armed got %b want 1", busy); end
      send_frame(2, 4, 8'hF8, 8'h00, 1'b0);
      wait_cyc(20);
      n_tests++;
      if (cap_pix.size() - base !== 8) begin
         n_fail++; $display("FAIL rgb565_count got %0d want 8", cap_pix.size() - base);
      end
      for (int k = 0; k < 8 && base + k < cap_pix.size(); k++) begin
         n_tests++;
         if (cap_pix[base+k] !== 16'hF800 || cap_h[base+k] !== 3'(k % 4) || cap_v[base+k] !== 2'(k / 4)) begin
            n_fail++;
            $display("FAIL rgb565_write%0d got pix=%h h=%0d v=%0d want pix=f800 h=%0d v=%0d",
                     k, cap_pix[base+k], cap_h[base+k], cap_v[base+k], k % 4, k / 4);
         end
      end
      n_tests++;
      if (done_cnt - based !== 1) begin n_fail++; $display("FAIL rgb565_done got %0d want 1", done_cnt - based); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rgb565_busy_end got %b want 0", busy); end
   endtask

   task automatic test_modes();
      logic [1:0]  tm  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      logic [7:0]  tb0 [6] = '{8'hF8, 8'h0F, 8'h0A, 8'h80, 8'h12, 8'hFF};
      logic [7:0]  tb1 [6] = '{8'h00, 8'h00, 8'h5C, 8'h00, 8'h34, 8'h00};
      logic [15:0] te  [6] = '{16'hF800, 16'hF800, 16'hAAB9, 16'h8410, 16'h1234, 16'hFFFF};
      int base;
      for (int i = 0; i < 6; i++) begin
         base = cap_pix.size();
         mode = tm[i];
         pulse_start();
         send_frame(1, 1, tb0[i], tb1[i], 1'b0);
         wait_cyc(20);
         n_tests++;
         if (cap_pix.size() - base !== 1) begin
            n_fail++; $display("FAIL mode_case%0d_count got %0d want 1", i, cap_pix.size() - base);
         end else if (cap_pix[base] !== te[i]) begin
            n_fail++; $display("FAIL mode_case%0d_pixel got %h want %h", i, cap_pix[base], te[i]);
         end
      end
      mode = 2'b00;
   endtask

   task automatic test_decimate();
      int base;
      logic [15:0] ep;
      base = cap_pix.size();
      dec = 1'b1;
      pulse_start();
      send_frame(4, 8, 8'h00, 8'hA5, 1'b1);
      wait_cyc(20);
      dec = 1'b0;
      n_tests++;
      if (cap_pix.size() - base !== 8) begin
         n_fail++; $display("FAIL decimate_count got %0d want 8", cap_pix.size() - base);
      end
      for (int k = 0; k < 8 && base + k < cap_pix.size(); k++) begin
         ep = {4'((k % 4) * 2), 4'((k / 4) * 2), 8'hA5};
         n_tests++;
         if (cap_pix[base+k] !== ep || cap_h[base+k] !== 3'(k % 4) || cap_v[base+k] !== 2'(k / 4)) begin
            n_fail++;
            $display("FAIL decimate_write%0d got pix=%h h=%0d v=%0d want pix=%h h=%0d v=%0d",
                     k, cap_pix[base+k], cap_h[base+k], cap_v[base+k], ep, k % 4, k / 4);
         end
      end
   endtask

   task automatic test_wait_vs();
      int base;
      bus.i_VS = 1'b0;
      wait_cyc(12);
      base = cap_pix.size();
      pulse_start();
      send_line(2, 8'hF8, 8'h00, 1'b0, 0);
      send_line(2, 8'hF8, 8'h00, 1'b0, 1);
      n_tests++;
      if (cap_pix.size() - base !== 0) begin
         n_fail++; $display("FAIL waitvs_no_write got %0d want 0", cap_pix.size() - base);
      end
      send_frame(1, 1, 8'h12, 8'h34, 1'b0);
      wait_cyc(20);
      n_tests++;
      if (cap_pix.size() - base !== 1) begin
         n_fail++; $display("FAIL waitvs_count got %0d want 1", cap_pix.size() - base);
      end else if (cap_pix[base] !== 16'h1234 || cap_h[base] !== 3'd0 || cap_v[base] !== 2'd0) begin
         n_fail++; $display("FAIL waitvs_write got pix=%h h=%0d v=%0d want 1234 0 0",
                            cap_pix[base], cap_h[base], cap_v[base]);
      end
   endtask

   task automatic test_back_to_back();
      int base, based;
      base = cap_pix.size();
      based = done_cnt;
      cont = 1'b1;
      pulse_start();
      send_frame(1, 2, 8'h11, 8'h22, 1'b0);
      send_frame(1, 2, 8'h33, 8'h44, 1'b0);
      n_tests++;
      if (done_cnt - based !== 2) begin n_fail++; $display("FAIL cont_done got %0d want 2", done_cnt - based); end
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_rearmed_busy got %b want 1", busy); end
      n_tests++;
      if (cap_pix.size() - base !== 4) begin
         n_fail++; $display("FAIL cont_count got %0d want 4", cap_pix.size() - base);
      end else if (cap_pix[base+1] !== 16'h1122 || cap_pix[base+2] !== 16'h3344) begin
         n_fail++; $display("FAIL cont_pixels got %h,%h want 1122,3344", cap_pix[base+1], cap_pix[base+2]);
      end
      cont = 1'b0;
      send_frame(1, 1, 8'h55, 8'h66, 1'b0);
      wait_cyc(20);
      n_tests++;
      if (busy !== 1'b0 || done_cnt - based !== 3) begin
         n_fail++; $display("FAIL cont_stop got busy=%b done=%0d want busy=0 done=3", busy, done_cnt - based);
      end
      n_tests++;
      if (cap_pix.size() - base !== 5) begin
         n_fail++; $display("FAIL cont_last_count got %0d want 5", cap_pix.size() - base);
      end else if (cap_pix[base+4] !== 16'h5566) begin
         n_fail++; $display("FAIL cont_last_pixel got %h want 5566", cap_pix[base+4]);
      end
   endtask

   task automatic test_size_err();
      int base;
      base = cap_pix.size();
      pulse_start();
      send_frame(1, 5, 8'hF8, 8'h00, 1'b0);
      wait_cyc(20);
      n_tests++;
      if (cap_pix.size() - base !== 4) begin
         n_fail++; $display("FAIL size_count got %0d want 4", cap_pix.size() - base);
      end else if (cap_h[base+3] !== 3'd3) begin
         n_fail++; $display("FAIL size_last_h got %0d want 3", cap_h[base+3]);
      end
      n_tests++;
      if (serr !== 1'b1) begin n_fail++; $display("FAIL size_err_set got %b want 1", serr); end
      wait_cyc(5);
      n_tests++;
      if (serr !== 1'b1) begin n_fail++; $display("FAIL size_err_sticky got %b want 1", serr); end
      pulse_start();
      wait_cyc(2);
      n_tests++;
      if (serr !== 1'b0) begin n_fail++; $display("FAIL size_err_clear got %b want 0", serr); end
   endtask

   task automatic test_reset_midframe();
      int base, based;
      base = cap_pix.size();
      based = done_cnt;
      bus.i_VS = 1'b0;
      wait_cyc(12);
      bus.i_HS = 1'b1;
      wait_cyc(2);
      for (int x = 0; x < 2; x++) begin
         send_byte(8'hF8);
         send_byte(8'h00);
      end
      n_tests++;
      if (busy !== 1'b1 || cap_pix.size() - base !== 2) begin
         n_fail++; $display("FAIL midreset_before got busy=%b writes=%0d want busy=1 writes=2",
                            busy, cap_pix.size() - base);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_pixel_data !== 16'h0 || bus.o_h_addr !== 3'd0 ||
          bus.o_v_addr !== 2'd0 || bus.o_XCLK !== 1'b0) begin
         n_fail++; $display("FAIL midreset_bus got v=%b pix=%h h=%0d v=%0d x=%b want all 0",
                            bus.o_valid, bus.o_pixel_data, bus.o_h_addr, bus.o_v_addr, bus.o_XCLK);
      end
      n_tests++;
      if (busy !== 1'b0 || fdone !== 1'b0 || serr !== 1'b0) begin
         n_fail++; $display("FAIL midreset_flags got busy=%b done=%b err=%b want 000", busy, fdone, serr);
      end
      wait_cyc(2);
      rst = 1'b0;
      for (int x = 0; x < 2; x++) begin
         send_byte(8'hF8);
         send_byte(8'h00);
      end
      bus.i_PCLK = 1'b0;
      wait_cyc(2);
      bus.i_HS = 1'b0;
      wait_cyc(8);
      bus.i_VS = 1'b1;
      wait_cyc(20);
      n_tests++;
      if (cap_pix.size() - base !== 2 || done_cnt != based) begin
         n_fail++; $display("FAIL midreset_after got writes=%0d done=%0d want writes=2 done=0",
                            cap_pix.size() - base, done_cnt - based);
      end
   endtask

   initial begin
      bus.i_PCLK = 1'b0;
      bus.i_VS   = 1'b0;
      bus.i_HS   = 1'b0;
      bus.i_DATA = 8'h00;
      test_reset();
      test_xclk();
      test_rgb565();
      test_modes();
      test_decimate();
      test_wait_vs();
      test_back_to_back();
      test_size_err();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
